// File: rtl/mem_arbiter.sv
// Arbitrates NUM_CONSUMERS LSU read/write ports onto one memory read and one memory
// write channel, one transaction in flight. Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin.
//   state         | meaning
//   IDLE          | choose a requester (read beats write on the same port)
//   READ_WAITING  | mem_read_valid held until mem_read_ready
//   WRITE_WAITING | mem_write_valid held until mem_write_ready
//   RELAYING      | completion pulse out, then wait for the served valid to drop
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);

    localparam int IDX_BITS = $clog2(NUM_CONSUMERS);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        READ_WAITING  = 2'd1,
        WRITE_WAITING = 2'd2,
        RELAYING      = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_BITS-1:0]            grant_q, grant_d;
    logic                           served_read_q, served_read_d;
    logic                           rd_valid_q, rd_valid_d;
    logic                           wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0]           rd_addr_q, rd_addr_d;
    logic [ADDR_BITS-1:0]           wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]           wr_data_q, wr_data_d;
    logic [NUM_CONSUMERS-1:0]       rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]       wr_ready_q, wr_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;

    logic [NUM_CONSUMERS-1:0]       req;
    logic                           found;
    logic [IDX_BITS-1:0]            pick;
    logic                           served_valid;

    assign req = consumer_read_valid | consumer_write_valid;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic [IDX_BITS-1:0] ptr_q, ptr_d;

    // First pass covers [ptr, N-1], second pass wraps to [0, ptr-1].
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (!found && req[i] && (i >= int'(ptr_q))) begin
                found = 1'b1;
                pick  = IDX_BITS'(i);
            end
        end
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                pick  = IDX_BITS'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && found) begin
            ptr_d = (int'(pick) == NUM_CONSUMERS - 1) ? '0 : pick + IDX_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                pick  = IDX_BITS'(i);
            end
        end
    end
`endif

    assign served_valid = served_read_q ? consumer_read_valid[grant_q]
                                        : consumer_write_valid[grant_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        served_read_d = served_read_q;
        rd_valid_d    = rd_valid_q;
        wr_valid_d    = wr_valid_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        rd_ready_d    = '0;
        wr_ready_d    = '0;
        rd_data_d     = rd_data_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    if (consumer_read_valid[pick]) begin
                        served_read_d = 1'b1;
                        rd_valid_d    = 1'b1;
                        rd_addr_d     = consumer_read_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
                        state_d       = READ_WAITING;
                    end else begin
                        served_read_d = 1'b0;
                        wr_valid_d    = 1'b1;
                        wr_addr_d     = consumer_write_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
                        wr_data_d     = consumer_write_data[int'(pick)*DATA_BITS +: DATA_BITS];
                        state_d       = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    rd_valid_d          = 1'b0;
                    rd_ready_d[grant_q] = 1'b1;
                    rd_data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
                    state_d             = RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    wr_valid_d          = 1'b0;
                    wr_ready_d[grant_q] = 1'b1;
                    state_d             = RELAYING;
                end
            end
            RELAYING: begin
                // The pulse cycle never exits, so a consumer reacting to the pulse
                // combinationally cannot shorten occupancy below four cycles.
                if (rd_ready_q == '0 && wr_ready_q == '0 && !served_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            served_read_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            wr_valid_q    <= 1'b0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_ready_q    <= '0;
            wr_ready_q    <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            served_read_q <= served_read_d;
            rd_valid_q    <= rd_valid_d;
            wr_valid_q    <= wr_valid_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rd_ready_q    <= rd_ready_d;
            wr_ready_q    <= wr_ready_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign consumer_read_ready  = rd_ready_q;
    assign consumer_read_data   = rd_data_q;
    assign consumer_write_ready = wr_ready_q;
    assign mem_read_valid       = rd_valid_q;
    assign mem_read_address     = rd_addr_q;
    assign mem_write_valid      = wr_valid_q;
    assign mem_write_address    = wr_addr_q;
    assign mem_write_data       = wr_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants/completions are queued as requests
// are driven and checked as the arbiter produces them. Memory returns addr ^ 0x99.
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AB = 8;
    localparam int DB = 8;

    typedef struct {
        int         idx;
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    consumer_read_valid;
    logic [N*AB-1:0] consumer_read_address;
    logic [N-1:0]    consumer_read_ready;
    logic [N*DB-1:0] consumer_read_data;
    logic [N-1:0]    consumer_write_valid;
    logic [N*AB-1:0] consumer_write_address;
    logic [N*DB-1:0] consumer_write_data;
    logic [N-1:0]    consumer_write_ready;
    logic            mem_read_valid;
    logic [AB-1:0]   mem_read_address;
    logic            mem_read_ready;
    logic [DB-1:0]   mem_read_data;
    logic            mem_write_valid;
    logic [AB-1:0]   mem_write_address;
    logic [DB-1:0]   mem_write_data;
    logic            mem_write_ready;

    int   vectors     = 0;
    int   miscompares = 0;
    txn_t exp_q[$];
    logic [7:0] last_rd [N];

    int   lat      = 0;
    logic mem_hold = 1'b0;
    int   spur_req = 0;
    int   spur_ack = 0;
    int   rd_cnt   = 0;
    int   wr_cnt   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    // Memory responder: one-cycle ready pulse 'lat' cycles after valid is first seen.
    initial begin
        mem_read_ready  = 1'b0;
        mem_read_data   = '0;
        mem_write_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_read_ready) begin
                mem_read_ready = 1'b0;
                rd_cnt = 0;
            end else if (spur_ack != spur_req) begin
                spur_ack       = spur_req;
                mem_read_ready = 1'b1;
                mem_read_data  = 8'hFF;
            end else if (mem_read_valid && !mem_hold) begin
                if (rd_cnt >= lat) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem_read_address ^ 8'h99;
                end else rd_cnt++;
            end else if (!mem_read_valid) rd_cnt = 0;

            if (mem_write_ready) begin
                mem_write_ready = 1'b0;
                wr_cnt = 0;
            end else if (mem_write_valid && !mem_hold) begin
                if (wr_cnt >= lat) mem_write_ready = 1'b1;
                else wr_cnt++;
            end else if (!mem_write_valid) wr_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*DB-1:0] last_rd_packed();
        logic [N*DB-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DB +: DB] = last_rd[i];
        return v;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data,
             consumer_read_ready, consumer_write_ready, consumer_read_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rv=%b wv=%b ra=%h wa=%h wd=%h crr=%b cwr=%b crd=%h, all required 0",
                     mem_read_valid, mem_write_valid, mem_read_address, mem_write_address,
                     mem_write_data, consumer_read_ready, consumer_write_ready, consumer_read_data);
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if ({mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready} !== '0) begin
                miscompares++;
                $display("FAIL idle_after_reset: rv=%b wv=%b crr=%b cwr=%b required all 0",
                         mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready);
            end
        end
    endtask

    task automatic test_single_read();
        txn_t t;
        bit   done = 0;
        bit   addr_ok = 1;
        lat = 2;
        exp_q.push_back('{idx: 2, is_wr: 1'b0, addr: 8'h3C, data: 8'hA5});
        @(negedge clk);
        consumer_read_address[2*AB +: AB] = 8'h3C;
        consumer_read_valid[2] = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_read_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL read_grant_latency: mem_read_valid=%b required 1", mem_read_valid);
        end
        t = exp_q.pop_front();
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (mem_read_valid && mem_read_address !== t.addr) addr_ok = 0;
            if (consumer_read_ready != '0) begin
                done = 1;
                vectors++;
                if (consumer_read_ready !== N'(1 << t.idx)) begin
                    miscompares++;
                    $display("FAIL read_ready_port: got %b required %b", consumer_read_ready, N'(1 << t.idx));
                end
                vectors++;
                if (consumer_read_data[t.idx*DB +: DB] !== t.data) begin
                    miscompares++;
                    $display("FAIL read_data: got %h required %h", consumer_read_data[t.idx*DB +: DB], t.data);
                end
                last_rd[t.idx] = t.data;
                consumer_read_valid[t.idx] = 1'b0;
            end
        end
        vectors++;
        if (!done || !addr_ok) begin
            miscompares++;
            $display("FAIL read_address_held: done=%0d addr_ok=%0d required 1/1 (addr 3c)", done, addr_ok);
        end
        @(negedge clk);
        vectors++;
        if (consumer_read_ready !== '0 || mem_read_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_pulse_width: crr=%b rv=%b required 0/0", consumer_read_ready, mem_read_valid);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_write();
        txn_t t;
        bit   done = 0;
        bit   held_ok = 1;
        lat = 3;
        exp_q.push_back('{idx: 1, is_wr: 1'b1, addr: 8'h10, data: 8'h7E});
        @(negedge clk);
        consumer_write_address[1*AB +: AB] = 8'h10;
        consumer_write_data[1*DB +: DB]    = 8'h7E;
        consumer_write_valid[1] = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_write_valid !== 1'b1 || mem_read_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL write_grant: wv=%b rv=%b required 1/0", mem_write_valid, mem_read_valid);
        end
        t = exp_q.pop_front();
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (mem_write_valid && (mem_write_address !== t.addr || mem_write_data !== t.data)) held_ok = 0;
            if (consumer_write_ready != '0) begin
                done = 1;
                vectors++;
                if (consumer_write_ready !== N'(1 << t.idx)) begin
                    miscompares++;
                    $display("FAIL write_ready_port: got %b required %b", consumer_write_ready, N'(1 << t.idx));
                end
                consumer_write_valid[t.idx] = 1'b0;
            end
        end
        vectors++;
        if (!done || !held_ok) begin
            miscompares++;
            $display("FAIL write_addr_data_held: done=%0d held_ok=%0d required 1/1 (10/7e)", done, held_ok);
        end
        @(negedge clk);
        vectors++;
        if (consumer_write_ready !== '0 || mem_write_valid !== 1'b0 || consumer_read_ready !== '0) begin
            miscompares++;
            $display("FAIL write_pulse_width: cwr=%b wv=%b crr=%b required 0", consumer_write_ready,
                     mem_write_valid, consumer_read_ready);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_arbitration_order();
        int         pending [N];
        int         lowcnt [N];
        int         rnd [N];
        int         served = 0;
        int         cyc = 0;
        int         last_grant = -1;
        logic       prev_valid = 1'b0;
        logic [7:0] a;
        txn_t       t;
        lat = 0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                a = 8'h40 + 8'(8*r + i);
                exp_q.push_back('{idx: i, is_wr: 1'b0, addr: a, data: a ^ 8'h99});
            end
`else
        for (int i = 0; i < N; i++)
            for (int r = 0; r < 2; r++) begin
                a = 8'h40 + 8'(8*r + i);
                exp_q.push_back('{idx: i, is_wr: 1'b0, addr: a, data: a ^ 8'h99});
            end
`endif
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            pending[i] = 2;
            lowcnt[i]  = 0;
            rnd[i]     = 0;
            consumer_read_address[i*AB +: AB] = 8'h40 + 8'(i);
            consumer_read_valid[i] = 1'b1;
        end
        while (served < 2*N && cyc < 200) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (lowcnt[i] > 0) begin
                    lowcnt[i]--;
                    if (lowcnt[i] == 0 && pending[i] > 0) begin
                        consumer_read_address[i*AB +: AB] = 8'h40 + 8'(8*rnd[i] + i);
                        consumer_read_valid[i] = 1'b1;
                    end
                end
            end
            if (mem_read_valid && !prev_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL grant_order: unexpected grant addr %h, none required", mem_read_address);
                end else begin
                    t = exp_q.pop_front();
                    if (mem_read_address !== t.addr) begin
                        miscompares++;
                        $display("FAIL grant_order: addr %h required %h (consumer %0d)",
                                 mem_read_address, t.addr, t.idx);
                    end
                    if (last_grant >= 0) begin
                        vectors++;
                        if (cyc - last_grant != 4) begin
                            miscompares++;
                            $display("FAIL occupancy: grant gap %0d cycles required 4", cyc - last_grant);
                        end
                    end
                    last_grant = cyc;
                end
            end
            prev_valid = mem_read_valid;
            if (consumer_read_ready != '0) begin
                vectors++;
                if (consumer_read_ready !== N'(1 << t.idx) ||
                    consumer_read_data[t.idx*DB +: DB] !== t.data) begin
                    miscompares++;
                    $display("FAIL order_completion: crr=%b data=%h required %b/%h", consumer_read_ready,
                             consumer_read_data[t.idx*DB +: DB], N'(1 << t.idx), t.data);
                end
                consumer_read_valid[t.idx] = 1'b0;
                last_rd[t.idx] = t.data;
                pending[t.idx]--;
                rnd[t.idx]++;
                lowcnt[t.idx] = 2;
                served++;
            end
        end
        vectors++;
        if (served != 2*N || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL order_timeout: served %0d left %0d required %0d/0", served, exp_q.size(), 2*N);
            exp_q.delete();
        end
        consumer_read_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read_write_same_port();
        txn_t       t;
        int         done = 0;
        int         cyc = 0;
        logic       prev_r = 1'b0;
        logic       prev_w = 1'b0;
        logic [7:0] got;
        lat = 1;
        exp_q.push_back('{idx: 3, is_wr: 1'b0, addr: 8'h33, data: 8'hAA});
        exp_q.push_back('{idx: 3, is_wr: 1'b1, addr: 8'h34, data: 8'hC3});
        @(negedge clk);
        consumer_read_address[3*AB +: AB]  = 8'h33;
        consumer_write_address[3*AB +: AB] = 8'h34;
        consumer_write_data[3*DB +: DB]    = 8'hC3;
        consumer_read_valid[3]  = 1'b1;
        consumer_write_valid[3] = 1'b1;
        while (done < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if ((mem_read_valid && !prev_r) || (mem_write_valid && !prev_w)) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rw_order: unexpected grant rv=%b wv=%b", mem_read_valid, mem_write_valid);
                end else begin
                    t = exp_q.pop_front();
                    got = t.is_wr ? mem_write_address : mem_read_address;
                    if ({mem_write_valid, mem_read_valid} !== (t.is_wr ? 2'b10 : 2'b01) || got !== t.addr ||
                        (t.is_wr && mem_write_data !== t.data)) begin
                        miscompares++;
                        $display("FAIL rw_order: wv/rv=%b%b addr %h wd %h required is_wr=%b addr %h",
                                 mem_write_valid, mem_read_valid, got, mem_write_data, t.is_wr, t.addr);
                    end
                end
            end
            prev_r = mem_read_valid;
            prev_w = mem_write_valid;
            if (consumer_read_ready != '0) begin
                vectors++;
                if (consumer_read_ready !== 4'b1000 || consumer_read_data[3*DB +: DB] !== 8'hAA) begin
                    miscompares++;
                    $display("FAIL rw_read_done: crr=%b data=%h required 1000/aa",
                             consumer_read_ready, consumer_read_data[3*DB +: DB]);
                end
                last_rd[3] = 8'hAA;
                consumer_read_valid[3] = 1'b0;
                done++;
            end
            if (consumer_write_ready != '0) begin
                vectors++;
                if (consumer_write_ready !== 4'b1000) begin
                    miscompares++;
                    $display("FAIL rw_write_done: cwr=%b required 1000", consumer_write_ready);
                end
                consumer_write_valid[3] = 1'b0;
                done++;
            end
        end
        vectors++;
        if (done != 2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rw_timeout: completions %0d left %0d required 2/0", done, exp_q.size());
            exp_q.delete();
        end
        consumer_read_valid  = '0;
        consumer_write_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        bit seen = 0;
        bit done = 0;
        mem_hold = 1'b1;
        @(negedge clk);
        consumer_write_address[0 +: AB] = 8'h22;
        consumer_write_data[0 +: DB]    = 8'h5A;
        consumer_write_valid[0] = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_write_valid) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL midwrite_grant: mem_write_valid never rose, required 1");
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data,
             consumer_read_ready, consumer_write_ready, consumer_read_data} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: wv=%b wa=%h wd=%h crd=%h required all 0",
                     mem_write_valid, mem_write_address, mem_write_data, consumer_read_data);
        end
        for (int i = 0; i < N; i++) last_rd[i] = 8'h00;
        consumer_write_valid = '0;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (consumer_write_ready !== '0 || mem_write_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: cwr=%b wv=%b required 0/0", consumer_write_ready, mem_write_valid);
            end
        end
        reset    = 1'b1;
        mem_hold = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (consumer_write_ready !== '0 || mem_write_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL no_pulse_after_reset: cwr=%b wv=%b required 0/0",
                         consumer_write_ready, mem_write_valid);
            end
        end
        lat = 0;
        consumer_read_address[2*AB +: AB] = 8'h55;
        consumer_read_valid[2] = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (consumer_read_ready != '0) begin
                done = 1;
                vectors++;
                if (consumer_read_ready !== 4'b0100 || consumer_read_data[2*DB +: DB] !== 8'hCC) begin
                    miscompares++;
                    $display("FAIL post_reset_read: crr=%b data=%h required 0100/cc",
                             consumer_read_ready, consumer_read_data[2*DB +: DB]);
                end
                last_rd[2] = 8'hCC;
                consumer_read_valid[2] = 1'b0;
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL post_reset_timeout: no completion, required one");
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_spurious_ready();
        bit done = 0;
        lat = 0;
        @(negedge clk);
        spur_req++;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (consumer_read_ready !== '0 || mem_read_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL spurious_ready: crr=%b rv=%b required 0/0", consumer_read_ready, mem_read_valid);
            end
        end
        vectors++;
        if (consumer_read_data !== last_rd_packed()) begin
            miscompares++;
            $display("FAIL read_data_hold: crd=%h required %h", consumer_read_data, last_rd_packed());
        end
        consumer_read_address[1*AB +: AB] = 8'h77;
        consumer_read_valid[1] = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h77) begin
            miscompares++;
            $display("FAIL idle_after_spurious: rv=%b addr=%h required 1/77", mem_read_valid, mem_read_address);
        end
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (consumer_read_ready != '0) begin
                done = 1;
                vectors++;
                if (consumer_read_ready !== 4'b0010 || consumer_read_data[1*DB +: DB] !== 8'hEE) begin
                    miscompares++;
                    $display("FAIL spurious_followup: crr=%b data=%h required 0010/ee",
                             consumer_read_ready, consumer_read_data[1*DB +: DB]);
                end
                last_rd[1] = 8'hEE;
                consumer_read_valid[1] = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if (!done || consumer_read_data !== last_rd_packed()) begin
            miscompares++;
            $display("FAIL final_read_data: done=%0d crd=%h required 1/%h", done, consumer_read_data,
                     last_rd_packed());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        for (int i = 0; i < N; i++) last_rd[i] = 8'h00;
        reset = 1'b1;
        #1 reset = 1'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_arbitration_order();
        test_read_write_same_port();
        test_reset_mid_write();
        test_spurious_ready();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, number of LSU request ports (range 2..16).
REQ-002 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port consumer_read_valid  input  NUM_CONSUMERS  per-LSU read request.
REQ-007 SHALL have port consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  per-LSU read address, packed, port i at bits [i*ADDR_BITS +: ADDR_BITS].
REQ-008 SHALL have port consumer_read_ready  output  NUM_CONSUMERS  per-LSU read completion pulse.
REQ-009 SHALL have port consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  per-LSU read data, packed.
REQ-010 SHALL have port consumer_write_valid  input  NUM_CONSUMERS  per-LSU write request.
REQ-011 SHALL have port consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  per-LSU write address, packed.
REQ-012 SHALL have port consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  per-LSU write data, packed.
REQ-013 SHALL have port consumer_write_ready  output  NUM_CONSUMERS  per-LSU write completion pulse.
REQ-014 SHALL have ports mem_read_valid (out, 1), mem_read_address (out, ADDR_BITS), mem_read_ready (in, 1) and mem_read_data (in, DATA_BITS): the single memory read channel.
REQ-015 SHALL have ports mem_write_valid (out, 1), mem_write_address (out, ADDR_BITS), mem_write_data (out, DATA_BITS) and mem_write_ready (in, 1): the single memory write channel.

Function
REQ-016 SHALL implement FSM states IDLE, READ_WAITING, WRITE_WAITING and RELAYING, with one outstanding memory transaction at most.
REQ-017 In IDLE, SHALL select one consumer i with read_valid or write_valid asserted; if both are asserted on the same consumer, the read SHALL win.
REQ-018 On a grant in cycle t, SHALL register the address (and data for a write) and assert mem_read_valid or mem_write_valid from cycle t+1, entering READ_WAITING or WRITE_WAITING.
REQ-019 SHALL hold mem_*_valid, address and data stable until the matching mem_*_ready is sampled high.
REQ-020 In READ_WAITING, when mem_read_ready is sampled high in cycle k, SHALL deassert mem_read_valid, drive consumer_read_data[i] = mem_read_data and pulse consumer_read_ready[i] for exactly one cycle at k+1, then enter RELAYING.
REQ-021 In WRITE_WAITING, when mem_write_ready is sampled high in cycle k, SHALL deassert mem_write_valid, pulse consumer_write_ready[i] for one cycle at k+1, then enter RELAYING.
REQ-022 consumer_read_data[i] SHALL hold its last value until that port's next read completes.
REQ-023 In RELAYING, SHALL wait until the granted consumer's served valid is low, then return to IDLE; a new grant SHALL NOT occur in the same cycle.
REQ-024 SHALL ignore mem_*_ready when no transaction is outstanding, and ignore requests from non-granted consumers until IDLE.
REQ-025 Minimum occupancy per transaction with a zero-wait memory SHALL be 4 cycles, from grant to next grant.

Reset
REQ-026 While reset is low, SHALL immediately force state = IDLE, the arbitration pointer = 0 and every output to 0, including mid-transaction; no completion pulse SHALL follow.
REQ-027 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with reset high.

Configuration
REQ-028 With macro MEM_ARBITER_ROUND_ROBIN_EN defined, SHALL search from pointer p upward with wrap-around, and set p = (i+1) mod NUM_CONSUMERS after granting i.
REQ-029 Without MEM_ARBITER_ROUND_ROBIN_EN, SHALL grant the lowest-index requesting consumer, with no pointer state.

Verification
REQ-030 Single read: consumer 2 requests address 0x3C, memory returns 0xA5 with 2-cycle latency -> mem_read_address = 0x3C, consumer_read_data[2] = 0xA5, one-cycle consumer_read_ready[2].
REQ-031 Single write: consumer 1 writes 0x7E to 0x10 -> mem_write_address = 0x10, mem_write_data = 0x7E held until ready, one-cycle consumer_write_ready[1].
REQ-032 All four consumers request reads at once, with round-robin enabled -> grant order 0,1,2,3; repeated -> 0,1,2,3; macro off -> a persistent consumer 0 is served every time.
REQ-033 Consumer 3 asserts read and write together -> read is served first, then the write is served on the following grant.
REQ-034 Reset is pulled low during WRITE_WAITING -> all outputs are 0 asynchronously, no consumer_write_ready pulse, and the next request after release is served normally.
REQ-035 Spurious mem_read_ready in IDLE -> no consumer_read_ready pulse and no state change.
